// File: rtl/q7_shiftsubdiv.sv
// q7_shiftsubdiv: sequential restoring (shift-subtract) unsigned divider.
// Divides a 2n-bit dividend by an n-bit divisor, producing one quotient bit
// per clock. It uses the same start/stop handshake as the shift-add
// multiplier. Results are registered and exposed only on completion.
module q7_shiftsubdiv #(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*n-1:0] i_A,
  input  logic [n-1:0]   i_B,
  output logic           stop,
  output logic [n-1:0]   o_Q,
  output logic [n-1:0]   o_R,
  output logic           o_ovf
);

  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_INIT = CW'(n);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic          start_d_r;
  logic [n-1:0]  rem_r, rem_s;
  logic [n-1:0]  sh_r, sh_s;
  logic [n-1:0]  div_r, div_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          stop_r, stop_s;
  logic [n-1:0]  q_r, q_s;
  logic [n-1:0]  r_r, r_s;
  logic          ovf_r, ovf_s;

  // Iteration datapath: shift the next dividend bit into the remainder and
  // conditionally subtract the divisor at n+1 bits.
  logic [n:0]   trial_s;
  logic [n:0]   diff_s;
  logic         ge_s;
  logic [n-1:0] rem_nx_s;
  logic [n-1:0] sh_nx_s;
  logic         accept_s;
  logic         ovf_in_s;
  logic         last_s;

  assign trial_s  = {rem_r, sh_r[n-1]};
  assign ge_s     = (trial_s >= {1'b0, div_r});
  assign diff_s   = trial_s - {1'b0, div_r};
  assign rem_nx_s = ge_s ? diff_s[n-1:0] : trial_s[n-1:0];
  assign sh_nx_s  = {sh_r[n-2:0], ge_s};
  assign last_s   = (cnt_r == CNT_ONE);

  // A start edge is only honoured while no division is in flight.
  assign accept_s = start && !start_d_r && ((state_r == IDLE) || (state_r == DONE));
  // Quotient cannot fit in n bits when the dividend's upper half reaches the
  // divisor; this also covers division by zero.
  assign ovf_in_s = (i_A[2*n-1:n] >= i_B);

  // State, datapath and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      start_d_r <= 1'b0;
      rem_r     <= {n{1'b0}};
      sh_r      <= {n{1'b0}};
      div_r     <= {n{1'b0}};
      cnt_r     <= {CW{1'b0}};
      stop_r    <= 1'b0;
      q_r       <= {n{1'b0}};
      r_r       <= {n{1'b0}};
      ovf_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      start_d_r <= start;
      rem_r     <= rem_s;
      sh_r      <= sh_s;
      div_r     <= div_s;
      cnt_r     <= cnt_s;
      stop_r    <= stop_s;
      q_r       <= q_s;
      r_r       <= r_s;
      ovf_r     <= ovf_s;
    end
  end

  // Next-state logic for the IDLE/RUN/DONE controller.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          state_s = ovf_in_s ? DONE : RUN;
        end else begin
          state_s = state_r;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values for the datapath and the result registers; results only
  // move on completion so the previous answer is held through RUN.
  always_comb begin
    rem_s  = rem_r;
    sh_s   = sh_r;
    div_s  = div_r;
    cnt_s  = cnt_r;
    stop_s = stop_r;
    q_s    = q_r;
    r_s    = r_r;
    ovf_s  = ovf_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s && ovf_in_s) begin
          stop_s = 1'b1;
          ovf_s  = 1'b1;
          q_s    = {n{1'b1}};
          r_s    = {n{1'b0}};
        end else if (accept_s) begin
          rem_s  = i_A[2*n-1:n];
          sh_s   = i_A[n-1:0];
          div_s  = i_B;
          cnt_s  = CNT_INIT;
          stop_s = 1'b0;
        end else begin
          stop_s = stop_r;
        end
      end
      RUN: begin
        rem_s = rem_nx_s;
        sh_s  = sh_nx_s;
        cnt_s = cnt_r - CNT_ONE;
        if (last_s) begin
          q_s    = sh_nx_s;
          r_s    = rem_nx_s;
          ovf_s  = 1'b0;
          stop_s = 1'b1;
        end else begin
          stop_s = 1'b0;
        end
      end
      default: begin
        stop_s = 1'b0;
      end
    endcase
  end

  assign stop  = stop_r;
  assign o_Q   = q_r;
  assign o_R   = r_r;
  assign o_ovf = ovf_r;

endmodule
